// File: rtl/reply_arbiter.sv
// ---------------------------------------------------------------------------
// reply_arbiter
//
// Shares the single 16-bit RX reply channel between two reply producers:
//   port 0 = command reader, port 1 = status/event reporter.
// Grants are packet-atomic and round-robin. Packets are capped at MAX_WORDS
// words, and every packet close is followed by GAP_CYCLES idle cycles.
//
// Handshake (valid/ready): wrN is the producer's valid and enN is its ready.
// A word is accepted on a rising txclk edge only when wrN and enN are both
// high in BUSYn; dataN must be stable with wrN. enN is combinational
// (rx_WR_enabled & gntN). A write with enN low is discarded and flagged.
// doneN is a one-cycle end-of-packet pulse. It may coincide with the last
// word; that word is forwarded first, and the close follows.
//
// Ports:
//   txclk, reset            clock, synchronous active-high reset
//   req0/1                  channel request, held until the producer's done
//   gnt0/1                  registered grant, one-hot or zero
//   en0/1                   write enable to producer (rx_WR_enabled & gntN)
//   wr0/1, data0/1, done0/1 producer word strobe, word, end-of-packet
//   rx_WR_enabled           downstream builder can accept a word
//   rx_WR, rx_databus       registered word strobe and word to the builder
//   rx_WR_done              registered one-cycle end-of-packet pulse
//   drop_err                sticky: write attempted while enN low
//   trunc_err               sticky: MAX_WORDS reached without done
//   abort_err               sticky: req dropped mid-packet without done
//   word_cnt                words forwarded in the current grant
//   state_dbg               FSM state for observation
//                           (0 IDLE, 1 BUSY0, 2 BUSY1, 3 CLOSE, 4 GAP)
// ---------------------------------------------------------------------------
module reply_arbiter #(
    parameter int MAX_WORDS  = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        en0,
    output logic        en1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic        done0,
    input  logic        done1,
    input  logic        rx_WR_enabled,
    output logic        rx_WR,
    output logic [15:0] rx_databus,
    output logic        rx_WR_done,
    output logic        drop_err,
    output logic        trunc_err,
    output logic        abort_err,
    output logic [7:0]  word_cnt,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY0 = 3'd1,
        BUSY1 = 3'd2,
        CLOSE = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] MAX_W    = 8'(MAX_WORDS);
    localparam bit         NO_GAP   = (GAP_CYCLES == 0);
    localparam logic [3:0] GAP_LAST = NO_GAP ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t      state, state_nx;
    logic        last_served, last_served_nx;
    logic        gnt0_nx, gnt1_nx;
    logic        rx_wr_nx;
    logic [15:0] rx_data_nx;
    logic        rx_done_nx;
    logic        drop_nx, trunc_nx, abort_nx;
    logic [7:0]  word_cnt_nx;
    logic [3:0]  gap_cnt, gap_cnt_nx;

    // After a truncation the producer is still inside its packet; its
    // remaining writes are swallowed and its request is kept out of
    // arbitration until it signals done (or drops the request).
    logic        flush0, flush1, flush0_nx, flush1_nx;

    // Signals of the port owning the current grant
    logic        sel1;
    logic        cur_req, cur_wr, cur_done, cur_en;
    logic [15:0] cur_data;
    logic        accept;
    logic        arb0, arb1;

    assign en0 = rx_WR_enabled & gnt0;
    assign en1 = rx_WR_enabled & gnt1;

    assign sel1     = (state == BUSY1);
    assign cur_req  = sel1 ? req1  : req0;
    assign cur_wr   = sel1 ? wr1   : wr0;
    assign cur_done = sel1 ? done1 : done0;
    assign cur_en   = sel1 ? en1   : en0;
    assign cur_data = sel1 ? data1 : data0;
    assign accept   = cur_wr & cur_en;

    assign arb0 = req0 & ~flush0;
    assign arb1 = req1 & ~flush1;

    assign state_dbg = state;

    always_comb begin
        state_nx       = state;
        last_served_nx = last_served;
        gnt0_nx        = gnt0;
        gnt1_nx        = gnt1;
        rx_wr_nx       = 1'b0;
        rx_data_nx     = rx_databus;
        rx_done_nx     = 1'b0;
        drop_nx        = drop_err;
        trunc_nx       = trunc_err;
        abort_nx       = abort_err;
        word_cnt_nx    = word_cnt;
        gap_cnt_nx     = gap_cnt;
        flush0_nx      = flush0 & req0 & ~done0;
        flush1_nx      = flush1 & req1 & ~done1;

        unique case (state)
            IDLE: begin
                // Tie goes to the port that was not served last
                if (arb0 && (!arb1 || last_served)) begin
                    state_nx       = BUSY0;
                    gnt0_nx        = 1'b1;
                    word_cnt_nx    = 8'd0;
                    last_served_nx = 1'b0;
                end else if (arb1) begin
                    state_nx       = BUSY1;
                    gnt1_nx        = 1'b1;
                    word_cnt_nx    = 8'd0;
                    last_served_nx = 1'b1;
                end
            end

            BUSY0, BUSY1: begin
                if (accept) begin
                    rx_wr_nx    = 1'b1;
                    rx_data_nx  = cur_data;
                    word_cnt_nx = (word_cnt == 8'hFF) ? 8'hFF : word_cnt + 8'd1;
                end
                if (cur_wr && !cur_en) begin
                    drop_nx = 1'b1;
                end
                // Close priority: done, then abort, then truncation
                if (cur_done) begin
                    state_nx = CLOSE;
                end else if (!cur_req) begin
                    state_nx = CLOSE;
                    abort_nx = 1'b1;
                end else if (accept && (word_cnt_nx == MAX_W)) begin
                    state_nx = CLOSE;
                    trunc_nx = 1'b1;
                    if (sel1) begin
                        flush1_nx = 1'b1;
                    end else begin
                        flush0_nx = 1'b1;
                    end
                end
            end

            CLOSE: begin
                // Grant stays up through this cycle so the done pulse
                // trails the last forwarded word by one cycle.
                gnt0_nx    = 1'b0;
                gnt1_nx    = 1'b0;
                rx_done_nx = 1'b1;
                gap_cnt_nx = 4'd0;
                state_nx   = NO_GAP ? IDLE : GAP;
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 4'd1;
                end
            end

            default: begin
                state_nx = IDLE;
                gnt0_nx  = 1'b0;
                gnt1_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rx_WR       <= 1'b0;
            rx_databus  <= 16'h0000;
            rx_WR_done  <= 1'b0;
            drop_err    <= 1'b0;
            trunc_err   <= 1'b0;
            abort_err   <= 1'b0;
            word_cnt    <= 8'd0;
            gap_cnt     <= 4'd0;
            flush0      <= 1'b0;
            flush1      <= 1'b0;
        end else begin
            state       <= state_nx;
            last_served <= last_served_nx;
            gnt0        <= gnt0_nx;
            gnt1        <= gnt1_nx;
            rx_WR       <= rx_wr_nx;
            rx_databus  <= rx_data_nx;
            rx_WR_done  <= rx_done_nx;
            drop_err    <= drop_nx;
            trunc_err   <= trunc_nx;
            abort_err   <= abort_nx;
            word_cnt    <= word_cnt_nx;
            gap_cnt     <= gap_cnt_nx;
            flush0      <= flush0_nx;
            flush1      <= flush1_nx;
        end
    end

endmodule
